// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial bit feeder.
// Holds the FSM state encoding and the completed-word counter width.
package bit_serializer_pkg;

  localparam int WORD_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with one-word skid buffer, feeding a serial detector.
// A pending word is chained directly behind the shifting one, so words stream gap-free.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [WORD_CNT_W-1:0] word_cnt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_t             state_r;
  ser_state_t             state_nxt_s;
  logic [WIDTH-1:0]       shift_r;
  logic [WIDTH-1:0]       shift_adv_s;
  logic [WIDTH-1:0]       pend_r;
  logic                   pend_full_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [CNT_W-1:0]       bit_cnt_nxt_s;
  logic                   out_last_r;
  logic [WORD_CNT_W-1:0]  word_cnt_r;
  logic                   in_xfer_s;
  logic                   out_xfer_s;
  logic                   last_xfer_s;
  logic                   load_pend_s;
  logic                   load_in_s;
  logic                   to_idle_s;
  logic                   pend_wr_s;

  // Transfer decode and next-state selection; pending word wins over bypass on the last bit.
  always_comb begin
    in_xfer_s     = in_valid & ~pend_full_r;
    out_xfer_s    = (state_r == SHIFT) & out_ready;
    last_xfer_s   = out_xfer_s & (bit_cnt_r == LAST_IDX);
    load_pend_s   = last_xfer_s & pend_full_r;
    load_in_s     = in_xfer_s & ((state_r == IDLE) | (last_xfer_s & ~pend_full_r));
    to_idle_s     = last_xfer_s & ~pend_full_r & ~in_xfer_s;
    pend_wr_s     = in_xfer_s & (state_r == SHIFT) & ~(last_xfer_s & ~pend_full_r);
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    if (load_pend_s | load_in_s) begin
      state_nxt_s   = SHIFT;
      bit_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (to_idle_s) begin
      state_nxt_s   = IDLE;
      bit_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
    end
    if (MSB_FIRST != 0) begin
      shift_adv_s = {shift_r[WIDTH-2:0], 1'b0};
    end else begin
      shift_adv_s = {1'b0, shift_r[WIDTH-1:1]};
    end
  end

  // Shift register; cleared when going idle so the serial line rests at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {WIDTH{1'b0}};
    end else if (load_pend_s) begin
      shift_r <= pend_r;
    end else if (load_in_s) begin
      shift_r <= in_data;
    end else if (to_idle_s) begin
      shift_r <= {WIDTH{1'b0}};
    end else if (out_xfer_s) begin
      shift_r <= shift_adv_s;
    end
  end

  // Pending-word register and its full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r      <= {WIDTH{1'b0}};
      pend_full_r <= 1'b0;
    end else if (pend_wr_s) begin
      pend_r      <= in_data;
      pend_full_r <= 1'b1;
    end else if (load_pend_s) begin
      pend_full_r <= 1'b0;
    end
  end

  // Control FSM with bit counter, registered last flag and saturating word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_cnt_r  <= {CNT_W{1'b0}};
      out_last_r <= 1'b0;
      word_cnt_r <= {WORD_CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      out_last_r <= (state_nxt_s == SHIFT) && (bit_cnt_nxt_s == LAST_IDX);
      if (last_xfer_s && (word_cnt_r != {WORD_CNT_W{1'b1}})) begin
        word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
      end
    end
  end

  assign in_ready  = ~pend_full_r;
  assign out_valid = (state_r == SHIFT);
  assign out_bit   = (MSB_FIRST != 0) ? shift_r[WIDTH-1] : shift_r[0];
  assign out_last  = out_last_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: vector table for single words and back-pressure,
// hand sequences for streaming, pending-full, mid-word reset and LSB-first mode.
module tb_bit_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] word_cnt;

  logic [7:0]  l_in_data;
  logic        l_in_valid;
  logic        l_in_ready;
  logic        l_out_bit;
  logic        l_out_valid;
  logic        l_out_last;
  logic [15:0] l_word_cnt;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .word_cnt(word_cnt)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .out_bit(l_out_bit), .out_valid(l_out_valid), .out_ready(1'b1), .out_last(l_out_last),
    .word_cnt(l_word_cnt)
  );

  always #5 clk = ~clk;

  // Serial monitor: records transferred bits, longest valid run and 1101 matches.
  logic        mon_clr;
  logic [63:0] mon_bits;
  int          mon_n, run_len, max_run, det_cnt;
  logic [2:0]  det_sh;

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_bits <= 64'd0;
      mon_n    <= 0;
      run_len  <= 0;
      max_run  <= 0;
      det_sh   <= 3'd0;
      det_cnt  <= 0;
    end else if (out_valid && out_ready) begin
      mon_bits <= {mon_bits[62:0], out_bit};
      mon_n    <= mon_n + 1;
      run_len  <= run_len + 1;
      if (run_len + 1 > max_run) max_run <= run_len + 1;
      det_sh   <= {det_sh[1:0], out_bit};
      if ({det_sh, out_bit} == 4'b1101) det_cnt <= det_cnt + 1;
    end else begin
      run_len <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int c = 0; c < max_cyc; c++) begin
      if (!out_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ov;
    logic       e_ob;
    logic       e_ol;
    logic       e_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic ov, input logic ob, input logic ol, input logic ir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = ov; v.e_ob = ob; v.e_ol = ol; v.e_ir = ir;
    vecs.push_back(v);
  endfunction

  logic [63:0] lbits;
  int          ln;

  initial begin
    // Single word 8'hD0, MSB first: 1,1,0,1,0,0,0,0 then idle.
    add(1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Word 8'hB4 with a 3-cycle stall mid-word and a 1-cycle stall on the last bit.
    add(1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    mon_clr    = 1'b1;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    l_in_valid = 1'b0;
    l_in_data  = 8'h00;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit",   {31'd0, out_bit},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_word_cnt",  {16'd0, word_cnt},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("vec%0d_out_bit", i),   {31'd0, out_bit},   {31'd0, vecs[i].e_ob});
      check($sformatf("vec%0d_out_last", i),  {31'd0, out_last},  {31'd0, vecs[i].e_ol});
      check($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("table_word_cnt", {16'd0, word_cnt}, 32'd2);

    // Streaming 8'hDD then 8'h0D back-to-back.
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hDD;
    @(posedge clk);
    #1;
    in_data = 8'h0D;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle(40, "stream_idle");
    check("stream_bits",    mon_bits[31:0], 32'h0000DD0D);
    check("stream_count",   mon_n,   32'd16);
    check("stream_no_gap",  max_run, 32'd16);
    check("stream_det",     det_cnt, 32'd3);
    check("stream_word_cnt", {16'd0, word_cnt}, 32'd4);

    // Pending full: F0 shifting, 33 pending, C3 held off until F0's last bit transfers.
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(posedge clk);
    #1;
    check("pend_ready_e0", {31'd0, in_ready}, 32'd1);
    in_data = 8'h33;
    @(posedge clk);
    #1;
    check("pend_ready_e1", {31'd0, in_ready}, 32'd0);
    in_data = 8'hC3;
    for (int k = 2; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pend_ready_e%0d", k), {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("pend_ready_e8", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pend_ready_e9", {31'd0, in_ready}, 32'd0);
    wait_idle(60, "pend_idle");
    check("pend_bits",   mon_bits[31:0], 32'h00F033C3);
    check("pend_count",  mon_n,   32'd24);
    check("pend_no_gap", max_run, 32'd24);
    check("pend_word_cnt", {16'd0, word_cnt}, 32'd7);

    // Reset after 4 bits of 8'hAA, then 8'h0F must shift cleanly.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_bit",   {31'd0, out_bit},   32'd0);
    check("mid_rst_out_last",  {31'd0, out_last},  32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mid_rst_word_cnt",  {16'd0, word_cnt},  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'h0F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_first_valid", {31'd0, out_valid}, 32'd1);
    wait_idle(40, "post_rst_idle");
    check("post_rst_bits",  mon_bits[31:0], 32'h0000000F);
    check("post_rst_count", mon_n, 32'd8);
    check("post_rst_word_cnt", {16'd0, word_cnt}, 32'd1);

    // LSB-first instance: 8'h0B shifts as 1,1,0,1,0,0,0,0.
    l_in_valid = 1'b1;
    l_in_data  = 8'h0B;
    @(posedge clk);
    #1;
    l_in_valid = 1'b0;
    lbits = 64'd0;
    ln    = 0;
    for (int c = 0; c < 20; c++) begin
      if (!l_out_valid) break;
      lbits = {lbits[62:0], l_out_bit};
      ln++;
      check($sformatf("lsb_last_%0d", ln), {31'd0, l_out_last}, (ln == 8) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    check("lsb_bits",     lbits[31:0], 32'h000000D0);
    check("lsb_count",    ln, 32'd8);
    check("lsb_idle_bit", {31'd0, l_out_bit}, 32'd0);
    check("lsb_word_cnt", {16'd0, l_word_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
